// File: rtl/stopwatch_key_ctrl.sv
// Key front end for the stopwatch: synchronizes and debounces three active-low keys,
// sequences OFF/RUN/PAUSE, generates the one-second tick and holds clear until a tick consumes it.
//   state | meaning
//   OFF   | counter disabled, tick generator held at 0
//   RUN   | counter enabled and counting
//   PAUSE | counter enabled but held (stop=1), tick still runs
module stopwatch_key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_CYCLES     = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key_n,
    output logic       en,
    output logic       stop,
    output logic       clear,
    output logic       tick_1s,
    output logic [1:0] state
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TKW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TKW-1:0] TK_LAST = TKW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [2:0]     sync_a;
    logic [2:0]     sync_b;
    logic [2:0]     deb;
    logic [2:0]     press;
    logic [DBW-1:0] db_cnt [3];
    logic [TKW-1:0] tick_cnt;
    logic           en_d;
    logic           stop_d;
    logic           clear_d;
    logic           ev_ss;
    logic           ev_clr;
    logic           ev_pwr;

    // press[i] is registered alongside the debounced value so the FSM reacts one edge later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 3'b111;
            sync_b <= 3'b111;
            deb    <= 3'b111;
            press  <= 3'b000;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync_a <= key_n;
            sync_b <= sync_a;
            press  <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (sync_b[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    deb[i]    <= sync_b[i];
                    press[i]  <= ~sync_b[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign ev_ss  = press[0];
    assign ev_clr = press[1];
    assign ev_pwr = press[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (state_q == ST_OFF || tick_cnt == TK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick_1s = (state_q != ST_OFF) && (tick_cnt == TK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
            en      <= 1'b0;
            stop    <= 1'b0;
            clear   <= 1'b0;
        end else begin
            state_q <= state_d;
            en      <= en_d;
            stop    <= stop_d;
            clear   <= clear_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF: begin
                if (ev_pwr) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ev_pwr)     state_d = ST_OFF;
                else if (ev_ss) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (ev_pwr)     state_d = ST_OFF;
                else if (ev_ss) state_d = ST_RUN;
            end
            default: state_d = ST_OFF;
        endcase

        en_d    = (state_d != ST_OFF);
        stop_d  = (state_d == ST_PAUSE);
        clear_d = clear;
        // a new clear request beats the tick that would otherwise retire it
        if (state_d == ST_OFF)                    clear_d = 1'b0;
        else if (ev_clr && state_q != ST_OFF)     clear_d = 1'b1;
        else if (tick_1s)                         clear_d = 1'b0;
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
// Directed bench for stopwatch_key_ctrl with small debounce/tick constants;
// expected values are queued when stimulus is applied and compared when outputs are sampled.
module tb_stopwatch_key_ctrl;

    localparam int DEB = 4;
    localparam int TCK = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] key_n = 3'b111;
    logic       en;
    logic       stop;
    logic       clear;
    logic       tick_1s;
    logic [1:0] state;
    logic [7:0] obs_vec;

    int ncmp = 0;
    int nerr = 0;
    int ecount = 0;
    int run_start = 0;
    int p_edge;
    int set_edge;
    int x_edge;
    int nt;

    string      tq[$];
    logic [7:0] vq[$];

    stopwatch_key_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_CYCLES    (TCK)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .key_n  (key_n),
        .en     (en),
        .stop   (stop),
        .clear  (clear),
        .tick_1s(tick_1s),
        .state  (state)
    );

    always #5 clk = ~clk;

    assign obs_vec = {3'b000, clear, stop, en, state};

    function automatic logic [7:0] pk(input logic [1:0] st, input logic e, input logic s, input logic c);
        return {3'b000, c, s, e, st};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic cycles(input int n);
        repeat (n) cyc();
    endtask

    task automatic expect_v(input string t, input logic [7:0] v);
        tq.push_back(t);
        vq.push_back(v);
    endtask

    task automatic compare(input logic [7:0] obs);
        string      t;
        logic [7:0] v;
        ncmp++;
        if (vq.size() == 0) begin
            nerr++;
            $error("FAIL scoreboard_empty: observed %0h expected none", obs);
        end else begin
            t = tq.pop_front();
            v = vq.pop_front();
            assert (obs === v) else begin
                nerr++;
                $error("FAIL %s: observed %0h expected %0h", t, obs, v);
            end
        end
    endtask

    task automatic count_ticks(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            cyc();
            if (tick_1s === 1'b1) cnt++;
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        expect_v("reset_async", pk(2'b00, 1'b0, 1'b0, 1'b0));
        compare(obs_vec);
        expect_v("reset_tick", 8'd0);
        compare({7'd0, tick_1s});
        cycles(3);
        rst = 1'b0;

        count_ticks(50, nt);
        expect_v("off_no_tick", 8'd0);
        compare(8'(nt));
        expect_v("off_idle", pk(2'b00, 1'b0, 1'b0, 1'b0));
        compare(obs_vec);

        // power on: exact latency DEB+3 edges
        key_n[2] = 1'b0;
        cycles(DEB + 2);
        expect_v("pwr_before", pk(2'b00, 1'b0, 1'b0, 1'b0));
        compare(obs_vec);
        cyc();
        expect_v("pwr_run", pk(2'b01, 1'b1, 1'b0, 1'b0));
        compare(obs_vec);
        run_start = ecount;
        key_n[2] = 1'b1;

        for (int k = 1; k <= 3 * TCK; k++) begin
            cyc();
            expect_v("tick_run", {7'd0, ((ecount - run_start) % TCK) == (TCK - 1)});
            compare({7'd0, tick_1s});
        end

        // bouncing start/stop press yields a single event
        key_n[0] = 1'b0;
        cycles(2);
        key_n[0] = 1'b1;
        cyc();
        key_n[0] = 1'b0;
        cycles(12);
        expect_v("bounce_pause", pk(2'b10, 1'b1, 1'b1, 1'b0));
        compare(obs_vec);
        key_n[0] = 1'b1;
        cycles(10);
        expect_v("release_no_event", pk(2'b10, 1'b1, 1'b1, 1'b0));
        compare(obs_vec);

        // clear in PAUSE is held until the edge after the next tick
        key_n[1] = 1'b0;
        p_edge   = ecount;
        set_edge = p_edge + DEB + 3;
        x_edge   = set_edge;
        while (((x_edge - run_start) % TCK) != (TCK - 1)) x_edge++;
        for (int k = 1; k <= x_edge + 1 - p_edge; k++) begin
            cyc();
            if (ecount == set_edge) key_n[1] = 1'b1;
            expect_v("clear_hold", {7'd0, (ecount >= set_edge) && (ecount <= x_edge)});
            compare({7'd0, clear});
        end
        expect_v("clear_done_state", pk(2'b10, 1'b1, 1'b1, 1'b0));
        compare(obs_vec);

        // second clean start/stop press resumes
        cycles(8);
        key_n[0] = 1'b0;
        cycles(DEB + 2);
        expect_v("resume_before", pk(2'b10, 1'b1, 1'b1, 1'b0));
        compare(obs_vec);
        cyc();
        expect_v("resume_run", pk(2'b01, 1'b1, 1'b0, 1'b0));
        compare(obs_vec);
        key_n[0] = 1'b1;

        // power and start/stop on the same edge: power wins
        cycles(10);
        key_n = 3'b010;
        cycles(DEB + 3);
        expect_v("both_off", pk(2'b00, 1'b0, 1'b0, 1'b0));
        compare(obs_vec);
        key_n = 3'b111;
        count_ticks(25, nt);
        expect_v("both_no_tick", 8'd0);
        compare(8'(nt));
        expect_v("both_still_off", pk(2'b00, 1'b0, 1'b0, 1'b0));
        compare(obs_vec);

        // clear is ignored in OFF
        key_n[1] = 1'b0;
        cycles(12);
        expect_v("clear_in_off", pk(2'b00, 1'b0, 1'b0, 1'b0));
        compare(obs_vec);
        key_n[1] = 1'b1;
        cycles(8);

        // reset in the middle of a power-key debounce
        key_n[2] = 1'b0;
        cycles(DEB + 3);
        expect_v("pwr_again", pk(2'b01, 1'b1, 1'b0, 1'b0));
        compare(obs_vec);
        key_n[2] = 1'b1;
        cycles(10);
        key_n[2] = 1'b0;
        cycles(2);
        rst = 1'b1;
        #1;
        expect_v("reset_mid_run", pk(2'b00, 1'b0, 1'b0, 1'b0));
        compare(obs_vec);
        expect_v("reset_mid_tick", 8'd0);
        compare({7'd0, tick_1s});
        cycles(2);
        rst = 1'b0;
        cycles(DEB + 2);
        expect_v("post_reset_before", pk(2'b00, 1'b0, 1'b0, 1'b0));
        compare(obs_vec);
        cyc();
        expect_v("post_reset_run", pk(2'b01, 1'b1, 1'b0, 1'b0));
        compare(obs_vec);
        run_start = ecount;
        key_n = 3'b111;
        for (int k = 1; k <= TCK + 1; k++) begin
            cyc();
            expect_v("tick_after_reset", {7'd0, ((ecount - run_start) % TCK) == (TCK - 1)});
            compare({7'd0, tick_1s});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
